// File: rtl/bc_pkg.sv
// bc_pkg: constants and a saturation helper shared by the brightness/contrast adjuster.
// Rev 1.0
`default_nettype none

package bc_pkg;

   localparam int BRIGHT_STEP = 16;
   localparam int BRIGHT_MIN  = -128;
   localparam int BRIGHT_MAX  = 112;
   localparam int CONTR_MIN   = 0;
   localparam int CONTR_MAX   = 31;
   localparam int CONTR_RST   = 8;
   localparam int CONTR_SHIFT = 3;
   localparam int PIPE_LAT    = 3;

   // Clamp a signed intermediate pixel value into the unsigned 8-bit range.
   function automatic logic [7:0] clamp_u8(input logic signed [11:0] s);
      if (s < 12'sd0)
         return 8'd0;
      else if (s > 12'sd255)
         return 8'd255;
      else
         return s[7:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/bc_channel.sv
// bc_channel: three-stage contrast/brightness pipeline for one 8-bit colour channel.
// Rev 1.0
`default_nettype none

module bc_channel
   import bc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic [7:0]        i_p,
   input  logic [4:0]        i_contr,
   input  logic signed [7:0] i_bright,
   output logic [7:0]        o_p
);

   logic signed [8:0]  w_d;
   logic signed [13:0] w_m;
   logic signed [10:0] w_mshift;
   logic signed [11:0] w_s;

   logic signed [13:0] r_m;
   logic signed [7:0]  r_bright;
   logic [7:0]         r_p1;
   logic               r_en1;
   logic signed [11:0] r_s;
   logic [7:0]         r_p2;
   logic               r_en2;

   always_comb begin
      w_d      = $signed({1'b0, i_p}) - 9'sd128;
      w_m      = w_d * $signed({1'b0, i_contr});
      w_mshift = 11'(r_m >>> CONTR_SHIFT);
      w_s      = 12'(w_mshift) + 12'sd128 + 12'(r_bright);
   end

   // Settings are captured alongside the pixel at S1 so later changes do not
   // disturb pixels already in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_m      <= '0;
         r_bright <= '0;
         r_p1     <= '0;
         r_en1    <= 1'b0;
         r_s      <= '0;
         r_p2     <= '0;
         r_en2    <= 1'b0;
         o_p      <= '0;
      end else begin
         r_m      <= w_m;
         r_bright <= i_bright;
         r_p1     <= i_p;
         r_en1    <= i_en;
         r_s      <= w_s;
         r_p2     <= r_p1;
         r_en2    <= r_en1;
         o_p      <= r_en2 ? clamp_u8(r_s) : r_p2;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bc_adjust.sv
// bc_adjust: frame-synchronised brightness/contrast settings and an RGB adjust pipeline.
// Rev 1.0
`default_nettype none

module bc_adjust
   import bc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              bc_en,
   input  logic              frame_en,
   input  logic              binc,
   input  logic              bdec,
   input  logic              cinc,
   input  logic              cdec,
   input  logic [7:0]        r_in,
   input  logic [7:0]        g_in,
   input  logic [7:0]        b_in,
   input  logic              pix_valid_in,
   output logic [7:0]        r_out,
   output logic [7:0]        g_out,
   output logic [7:0]        b_out,
   output logic              pix_valid_out,
   output logic signed [7:0] bright_lvl,
   output logic [4:0]        contr_lvl
);

   localparam logic signed [8:0] c_BMIN  = 9'(BRIGHT_MIN);
   localparam logic signed [8:0] c_BMAX  = 9'(BRIGHT_MAX);
   localparam logic signed [6:0] c_CMIN  = 7'(CONTR_MIN);
   localparam logic signed [6:0] c_CMAX  = 7'(CONTR_MAX);

   logic signed [7:0] r_bpend;
   logic signed [7:0] r_bact;
   logic [4:0]        r_cpend;
   logic [4:0]        r_cact;
   logic [PIPE_LAT-1:0] r_vld;

   logic signed [8:0] w_bstep;
   logic signed [8:0] w_bsum;
   logic signed [7:0] w_bnext;
   logic signed [6:0] w_cstep;
   logic signed [6:0] w_csum;
   logic [4:0]        w_cnext;

   always_comb begin
      w_bstep = '0;
      if (binc && !bdec)
         w_bstep = 9'(BRIGHT_STEP);
      else if (bdec && !binc)
         w_bstep = -9'(BRIGHT_STEP);
      w_bsum  = {r_bpend[7], r_bpend} + w_bstep;
      if (w_bsum < c_BMIN)
         w_bnext = 8'(BRIGHT_MIN);
      else if (w_bsum > c_BMAX)
         w_bnext = 8'(BRIGHT_MAX);
      else
         w_bnext = w_bsum[7:0];

      w_cstep = '0;
      if (cinc && !cdec)
         w_cstep = 7'sd1;
      else if (cdec && !cinc)
         w_cstep = -7'sd1;
      w_csum  = {2'b00, r_cpend} + w_cstep;
      if (w_csum < c_CMIN)
         w_cnext = 5'(CONTR_MIN);
      else if (w_csum > c_CMAX)
         w_cnext = 5'(CONTR_MAX);
      else
         w_cnext = w_csum[4:0];
   end

   // Active settings take the pending value as it stood before this cycle's pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bpend <= '0;
         r_bact  <= '0;
         r_cpend <= 5'(CONTR_RST);
         r_cact  <= 5'(CONTR_RST);
         r_vld   <= '0;
      end else begin
         r_bpend <= w_bnext;
         r_cpend <= w_cnext;
         if (frame_en) begin
            r_bact <= r_bpend;
            r_cact <= r_cpend;
         end
         r_vld <= {r_vld[PIPE_LAT-2:0], pix_valid_in};
      end
   end

   assign bright_lvl    = r_bact;
   assign contr_lvl     = r_cact;
   assign pix_valid_out = r_vld[PIPE_LAT-1];

   bc_channel u_ch_r (
      .clk      (clk),
      .rst      (rst),
      .i_en     (bc_en),
      .i_p      (r_in),
      .i_contr  (r_cact),
      .i_bright (r_bact),
      .o_p      (r_out)
   );

   bc_channel u_ch_g (
      .clk      (clk),
      .rst      (rst),
      .i_en     (bc_en),
      .i_p      (g_in),
      .i_contr  (r_cact),
      .i_bright (r_bact),
      .o_p      (g_out)
   );

   bc_channel u_ch_b (
      .clk      (clk),
      .rst      (rst),
      .i_en     (bc_en),
      .i_p      (b_in),
      .i_contr  (r_cact),
      .i_bright (r_bact),
      .o_p      (b_out)
   );

endmodule

`default_nettype wire

// File: doc/bc_adjust.md
BC_ADJUST -- requirements
Module: bc_adjust

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high; clock port clk, reset port rst.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset.
REQ-004 Port bc_en, input, 1 bit: enable[0] from control; 1 = apply adjustment, 0 = bypass.
REQ-005 Port frame_en, input, 1 bit: one-cycle frame-boundary strobe from control.
REQ-006 Ports binc, bdec, cinc, cdec, inputs, 1 bit each: one-cycle brightness and contrast up/down pulses from control.
REQ-007 Ports r_in, g_in, b_in, inputs, 8 bits each, plus pix_valid_in, input, 1 bit: incoming pixel.
REQ-008 Ports r_out, g_out, b_out, outputs, 8 bits each, plus pix_valid_out, output, 1 bit: adjusted pixel.
REQ-009 Port bright_lvl, output, signed 8 bits: active brightness offset.
REQ-010 Port contr_lvl, output, 5 bits: active contrast gain in units of 1/8.

Function
REQ-011 Pending brightness register: binc adds 16 and bdec subtracts 16 in the same cycle; the result saturates to the range -128..+112.
REQ-012 Pending contrast register: cinc adds 1 and cdec subtracts 1 in the same cycle; the result saturates to the range 0..31.
REQ-013 binc and bdec asserted in the same cycle SHALL leave pending brightness unchanged; the same rule applies to cinc and cdec for pending contrast.
REQ-014 Active registers (bright_lvl, contr_lvl) SHALL load the pending values only in a cycle with frame_en=1.
REQ-015 If frame_en and a pulse occur in the same cycle, the active registers load the pre-pulse pending value, and the pulse takes effect at the next frame_en.
REQ-016 Pixel path per channel, 3-stage pipeline, latency exactly 3 cycles:
- S1: d = p - 128 (signed 9-bit); m = d * contr_lvl (signed 14-bit).
- S2: s = (m >>> 3) + 128 + bright_lvl (signed 12-bit, arithmetic shift, floor).
- S3: clamp s to 0..255.
REQ-017 Settings used for a pixel SHALL be those active when the pixel enters S1; a frame_en mid-pipeline does not alter in-flight pixels.
REQ-018 When bc_en=0, out = in delayed 3 cycles, unmodified.
REQ-019 Pending and active registers SHALL still track pulses and frame_en while bc_en=0.
REQ-020 pix_valid_out SHALL equal pix_valid_in delayed 3 cycles.
REQ-021 Pipeline data SHALL advance every cycle regardless of valid; there is no backpressure.

Reset
REQ-022 On rst=1 at a clock edge, pending and active brightness SHALL be set to 0, and pending and active contrast SHALL be set to 8 (gain 1.0).
REQ-023 On rst=1, all pipeline valid bits SHALL clear, and pixel data outputs SHALL be set to 0.
REQ-024 pix_valid_out SHALL be 0 in the cycle after rst is sampled high, including when rst is asserted mid-stream; in-flight pixels are discarded.

Structure
REQ-025 Shared package bc_pkg SHALL hold the following constants: BRIGHT_STEP=16, BRIGHT_MIN=-128, BRIGHT_MAX=112, CONTR_MIN=0, CONTR_MAX=31, CONTR_RST=8, CONTR_SHIFT=3, PIPE_LAT=3.
REQ-026 Sub-module bc_channel SHALL implement the REQ-016 pipeline for one 8-bit channel and SHALL be instantiated three times (R, G, B).
REQ-027 The settings registers and the valid pipeline SHALL reside in bc_adjust.

Verification
REQ-028 Reset, then pixel (100,100,100) with valid, bc_en=1 -> (100,100,100) with valid exactly 3 cycles later; bright_lvl=0, contr_lvl=8.
REQ-029 Two binc pulses, no frame_en -> output unchanged at 100; after one frame_en, pixel 100 -> 132 and bright_lvl=32.
REQ-030 Ten binc pulses then frame_en -> bright_lvl=112; pixel 250 -> 255. Ten bdec pulses then frame_en -> bright_lvl=-48; pixel 10 -> 0.
REQ-031 Eight cinc pulses then frame_en (contr_lvl=16) -> pixel 192 -> 255, pixel 100 -> 72, pixel 128 -> 128.
REQ-032 binc and bdec together with cinc in the same cycle, then frame_en -> bright_lvl unchanged and contr_lvl +1. frame_en coincident with binc -> bright_lvl unchanged until the next frame_en.
REQ-033 bc_en=0 with contr_lvl=16 and bright_lvl=32 -> pixel 77 -> 77 at 3-cycle latency. rst asserted with 2 pixels in flight -> no valid output in the following cycles.
